// File: rtl/fp_mul_scheduler_pkg.sv
// fpm_sched_pkg: shared state encoding, widths and helpers for the fp multiplier scheduler
package fpm_sched_pkg;
  localparam int FP_W = 32;
  localparam int TIMEOUT_DEFAULT = 64;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fp_mul_scheduler_if.sv
// fp_mul_scheduler_if: requester, multiplier and response signals of the fp multiplier scheduler
interface fp_mul_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = fpm_sched_pkg::clog2(NUM_REQ)
);
  import fpm_sched_pkg::*;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*FP_W-1:0] req_fp1;
  logic [NUM_REQ*FP_W-1:0] req_fp2;
  logic                    mul_start;
  logic [FP_W-1:0]         mul_fp1;
  logic [FP_W-1:0]         mul_fp2;
  logic [FP_W-1:0]         mul_product;
  logic                    mul_overflow;
  logic                    mul_done;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [FP_W-1:0]         rsp_product;
  logic                    rsp_overflow;
  logic                    rsp_err;
  logic                    busy;
  modport master (
    output req_valid, req_fp1, req_fp2, mul_product, mul_overflow, mul_done, rsp_ready,
    input  req_ready, mul_start, mul_fp1, mul_fp2, rsp_valid, rsp_id, rsp_product, rsp_overflow, rsp_err, busy
  );
  modport slave (
    input  req_valid, req_fp1, req_fp2, mul_product, mul_overflow, mul_done, rsp_ready,
    output req_ready, mul_start, mul_fp1, mul_fp2, rsp_valid, rsp_id, rsp_product, rsp_overflow, rsp_err, busy
  );
endinterface

// File: rtl/fp_mul_scheduler_arb.sv
// fp_rr_arbiter: combinational round-robin pick of the first request after ptr
module fp_rr_arbiter import fpm_sched_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);
  logic [ID_W-1:0] idx;
  // scan from the farthest slot back toward ptr+1 so the nearest valid slot wins last
  always_comb begin
    grant = '0;
    grant_id = '0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
        grant_id = idx;
      end
    end
  end
endmodule

// File: rtl/fp_mul_scheduler.sv
// fp_mul_scheduler: shares one multi-cycle fp multiplier among requesters; FPM_TIMEOUT_EN adds a WAIT watchdog
module fp_mul_scheduler import fpm_sched_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input logic clk,
  input logic resetn,
  fp_mul_scheduler_if.slave bus
);
  state_t state, nstate;
  logic [FP_W-1:0] op1, op2, product;
  logic [ID_W-1:0] id, rr_ptr, gid;
  logic [NUM_REQ-1:0] grant;
  logic overflow, accept, capture, tmo;

  fp_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(bus.req_valid), .ptr(rr_ptr), .grant(grant), .grant_id(gid)
  );

  assign accept = state == IDLE && |bus.req_valid;
  assign capture = state == WAIT && bus.mul_done;

  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= nstate;

  // next state: done is only honoured in WAIT, so stale pulses in ISSUE/RESP are dropped
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = accept ? ISSUE : IDLE;
      ISSUE:   nstate = WAIT;
      WAIT:    nstate = (capture || tmo) ? RESP : WAIT;
      default: nstate = bus.rsp_ready ? IDLE : RESP;
    endcase
  end

  // operand capture on grant, result capture on done, pointer advance on response handoff
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op1 <= '0;
      op2 <= '0;
      id <= '0;
      product <= '0;
      overflow <= 1'b0;
      rr_ptr <= ID_W'(NUM_REQ - 1);
    end else begin
      if (accept) begin
        op1 <= bus.req_fp1[int'(gid)*FP_W +: FP_W];
        op2 <= bus.req_fp2[int'(gid)*FP_W +: FP_W];
        id <= gid;
      end
      if (capture) begin
        product <= bus.mul_product;
        overflow <= bus.mul_overflow;
      end else if (tmo) begin
        product <= '0;
        overflow <= 1'b0;
      end
      if (state == RESP && bus.rsp_ready) rr_ptr <= id;
    end
  end

`ifdef FPM_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic err;
  assign tmo = state == WAIT && !bus.mul_done && cnt == CW'(TIMEOUT_CYCLES - 1);
  // watchdog: restarts on WAIT entry, flags the response on expiry, clears on the next accept
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      err <= tmo ? 1'b1 : accept ? 1'b0 : err;
    end
  assign bus.rsp_err = err;
`else
  assign tmo = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = (accept && resetn) ? grant : '0;
  assign bus.mul_start = state == ISSUE;
  assign bus.mul_fp1 = op1;
  assign bus.mul_fp2 = op2;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_id = id;
  assign bus.rsp_product = product;
  assign bus.rsp_overflow = overflow;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_fp_mul_scheduler.sv
// tb_fp_mul_scheduler: directed vectors and corner sequences for the fp multiplier scheduler
module tb_fp_mul_scheduler;
  typedef struct {
    logic [3:0]  mask;
    int          eg;
    logic [31:0] a, b, p;
    logic        ov;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [3:0] rv = '0;
  logic [31:0] fa[4];
  logic [31:0] fb[4];
  logic [31:0] mprod = '0;
  logic movf = 1'b0;
  logic rr = 1'b0;
  logic extra_done = 1'b0;
  logic mdl_done = 1'b0;
  logic mdl_en = 1'b1;
  int lat = 1;
  int mcnt = 0;
  int total = 0;
  int bad = 0;
  vec_t tv[6];

  fp_mul_scheduler_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  fp_mul_scheduler #(.NUM_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  assign bus.req_valid = rv;
  assign bus.req_fp1 = {fa[3], fa[2], fa[1], fa[0]};
  assign bus.req_fp2 = {fb[3], fb[2], fb[1], fb[0]};
  assign bus.mul_product = mprod;
  assign bus.mul_overflow = movf;
  assign bus.mul_done = mdl_done | extra_done;
  assign bus.rsp_ready = rr;

  always #5 clk = ~clk;

  // multiplier model: one-cycle done pulse lat cycles after the start is seen
  always @(negedge clk) begin
    mdl_done = 1'b0;
    if (!resetn) mcnt = 0;
    else if (bus.mul_start && mdl_en) mcnt = lat;
    else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) mdl_done = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (!bus.rsp_valid && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    rv = '0;
    rr = 1'b0;
    extra_done = 1'b0;
    mdl_en = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic op_start(input logic [3:0] mask, input bit hold, input int eg, input int l);
    int n;
    lat = l;
    rv = mask;
    #1;
    chk("grant", bus.req_ready, 64'(1) << eg);
    @(negedge clk);
    if (!hold) rv = '0;
    chk("start", bus.mul_start, 1);
    chk("issue_fp1", bus.mul_fp1, fa[eg]);
    chk("issue_fp2", bus.mul_fp2, fb[eg]);
    chk("ready_issue", bus.req_ready, 0);
    wait_rsp(l + 8, n);
    chk("latency", n, l + 1);
  endtask

  task automatic op_finish(input int eg, input logic [31:0] p, input logic ov);
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_id", bus.rsp_id, eg);
    chk("rsp_product", bus.rsp_product, p);
    chk("rsp_overflow", bus.rsp_overflow, ov);
    chk("rsp_err", bus.rsp_err, 0);
    chk("resp_fp1", bus.mul_fp1, fa[eg]);
    rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
    chk("idle_after", bus.busy, 0);
    chk("rsp_drop", bus.rsp_valid, 0);
  endtask

  task automatic op(input logic [3:0] mask, input bit hold, input int eg, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] p, input logic ov, input int l);
    fa[eg] = a;
    fb[eg] = b;
    mprod = p;
    movf = ov;
    op_start(mask, hold, eg, l);
    op_finish(eg, p, ov);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] t2a[5];
    logic [31:0] t2p[5];
    tv[0] = '{4'b0010, 1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 3};
    tv[1] = '{4'b0101, 2, 32'hC0000000, 32'h3F000000, 32'hBF800000, 1'b0, 1};
    tv[2] = '{4'b0011, 0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 7};
    tv[3] = '{4'b1000, 3, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 2};
    tv[4] = '{4'b1001, 0, 32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 4};
    tv[5] = '{4'b1001, 3, 32'h3F000000, 32'h3F000000, 32'h3E800000, 1'b0, 2};
    t2a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h3F800000};
    t2p = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h40000000};
    for (int i = 0; i < 4; i++) begin
      fa[i] = '0;
      fb[i] = '0;
    end
    do_reset();
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_start", bus.mul_start, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_id", bus.rsp_id, 0);
    chk("rst_product", bus.rsp_product, 0);
    chk("rst_fp1", bus.mul_fp1, 0);
    chk("rst_err", bus.rsp_err, 0);
    // single request, 2.0 * 3.0
    op(4'b0001, 0, 0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 5);
    for (int i = 0; i < 6; i++)
      op(tv[i].mask, 0, tv[i].eg, tv[i].a, tv[i].b, tv[i].p, tv[i].ov, tv[i].lat);
    // response backpressure with other requesters waiting
    fa[0] = 32'h40800000;
    fb[0] = 32'h3F000000;
    mprod = 32'h40000000;
    movf = 1'b0;
    op_start(4'b0001, 0, 0, 2);
    rv = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_id", bus.rsp_id, 0);
      chk("bp_product", bus.rsp_product, 32'h40000000);
      chk("bp_ready", bus.req_ready, 0);
      chk("bp_start", bus.mul_start, 0);
    end
    op_finish(0, 32'h40000000, 1'b0);
    op(4'b1110, 0, 1, 32'h40000000, 32'hC0000000, 32'hC0800000, 1'b0, 2);
    // stale done pulses in ISSUE and RESP, 5.0 * 2.0
    fa[0] = 32'h40A00000;
    fb[0] = 32'h40000000;
    mprod = 32'h41200000;
    movf = 1'b0;
    lat = 4;
    rv = 4'b0001;
    @(negedge clk);
    rv = '0;
    chk("t4_start", bus.mul_start, 1);
    extra_done = 1'b1;
    mprod = 32'hDEADBEEF;
    movf = 1'b1;
    @(negedge clk);
    extra_done = 1'b0;
    mprod = 32'h41200000;
    movf = 1'b0;
    chk("t4_no_early_rsp", bus.rsp_valid, 0);
    wait_rsp(12, n);
    chk("t4_latency", n, 4);
    extra_done = 1'b1;
    mprod = 32'hDEADBEEF;
    movf = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t4_resp_valid", bus.rsp_valid, 1);
      chk("t4_resp_product", bus.rsp_product, 32'h41200000);
      chk("t4_resp_ovf", bus.rsp_overflow, 0);
    end
    extra_done = 1'b0;
    mprod = 32'h41200000;
    movf = 1'b0;
    op_finish(0, 32'h41200000, 1'b0);
    // asynchronous reset while waiting on the multiplier
    fa[0] = 32'h3F800000;
    lat = 20;
    rv = 4'b0001;
    @(negedge clk);
    rv = 4'b1110;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("ar_start", bus.mul_start, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_rsp_valid", bus.rsp_valid, 0);
    chk("ar_ready", bus.req_ready, 0);
    chk("ar_fp1", bus.mul_fp1, 0);
    chk("ar_id", bus.rsp_id, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    op(4'b1111, 0, 0, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 3);
    // all requesters held: strict rotation from requester 0
    do_reset();
    for (int i = 0; i < 4; i++) fb[i] = 32'h40000000;
    for (int i = 0; i < 5; i++) op(4'b1111, 1, i % 4, t2a[i], 32'h40000000, t2p[i], 1'b0, 2);
    rv = '0;
`ifdef FPM_TIMEOUT_EN
    mdl_en = 1'b0;
    mprod = 32'h12345678;
    movf = 1'b1;
    rv = 4'b0001;
    @(negedge clk);
    rv = '0;
    chk("to_start", bus.mul_start, 1);
    wait_rsp(20, n);
    chk("to_latency", n, 9);
    chk("to_err", bus.rsp_err, 1);
    chk("to_product", bus.rsp_product, 0);
    chk("to_ovf", bus.rsp_overflow, 0);
    rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
    mdl_en = 1'b1;
    op(4'b0010, 0, 1, 32'h40400000, 32'h40000000, 32'h40C00000, 1'b0, 3);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
